// File: rtl/store_write_buffer_if.sv
// CPU-side and cache-side signal bundle for the store write buffer.
// slave = the buffer itself; master = the CPU/cache environment around it.
interface store_write_buffer_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_write_data;
  logic        cpu_memwrite;
  logic        cpu_memread;
  logic [3:0]  cpu_sign_mask;
  logic [31:0] cpu_read_data;
  logic        cpu_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_sign_mask;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_read_data;
  logic        mem_clk_stall;

  modport slave (
    input  cpu_addr, cpu_write_data, cpu_memwrite, cpu_memread, cpu_sign_mask,
    output cpu_read_data, cpu_stall,
    output mem_addr, mem_write_data, mem_sign_mask, mem_memwrite, mem_memread,
    input  mem_read_data, mem_clk_stall
  );

  modport master (
    output cpu_addr, cpu_write_data, cpu_memwrite, cpu_memread, cpu_sign_mask,
    input  cpu_read_data, cpu_stall,
    input  mem_addr, mem_write_data, mem_sign_mask, mem_memwrite, mem_memread,
    output mem_read_data, mem_clk_stall
  );
endinterface

// File: rtl/store_write_buffer.sv
// Posted-store FIFO in front of the data cache's single-request port.
// Loads bypass queued stores unless they hit a queued word; in-flight stores stay queued until done.
module store_write_buffer #(
  parameter int DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  store_write_buffer_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {M_IDLE = 2'd0, M_REQ = 2'd1, M_WAIT = 2'd2} state_t;
  typedef enum logic {OP_STORE = 1'b0, OP_LOAD = 1'b1} op_t;

  logic [31:0]   fifo_addr_r [DEPTH];
  logic [31:0]   fifo_data_r [DEPTH];
  logic [3:0]    fifo_mask_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  state_t        state_r;
  op_t           op_r;
  logic [31:0]   mem_addr_r;
  logic [31:0]   mem_write_data_r;
  logic [3:0]    mem_sign_mask_r;
  logic          mem_memwrite_r;
  logic          mem_memread_r;

  logic complete_s;
  logic pop_s;
  logic load_done_s;
  logic full_s;
  logic push_s;
  logic hazard_s;

  assign complete_s  = (state_r == M_WAIT) && !bus.mem_clk_stall;
  assign pop_s       = complete_s && (op_r == OP_STORE);
  assign load_done_s = complete_s && (op_r == OP_LOAD);
  assign full_s      = (count_r == FULL_COUNT);
  assign push_s      = bus.cpu_memwrite && (!full_s || pop_s);

  assign bus.cpu_stall      = (bus.cpu_memread && !load_done_s) ||
                              (bus.cpu_memwrite && full_s && !pop_s);
  assign bus.cpu_read_data  = bus.mem_read_data;
  assign bus.mem_addr       = mem_addr_r;
  assign bus.mem_write_data = mem_write_data_r;
  assign bus.mem_sign_mask  = mem_sign_mask_r;
  assign bus.mem_memwrite   = mem_memwrite_r;
  assign bus.mem_memread    = mem_memread_r;

  // Word-address match of the pending load against every live entry, in-flight head included.
  always_comb begin
    logic [PW-1:0] off_v;
    hazard_s = 1'b0;
    off_v    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_v    = PW'(i) - rd_ptr_r;
      hazard_s = hazard_s | ((CW'(off_v) < count_r) &&
                             (fifo_addr_r[i][31:2] == bus.cpu_addr[31:2]));
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_r[i] <= 32'h0;
        fifo_data_r[i] <= 32'h0;
        fifo_mask_r[i] <= 4'h0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        fifo_addr_r[wr_ptr_r] <= bus.cpu_addr;
        fifo_data_r[wr_ptr_r] <= bus.cpu_write_data;
        fifo_mask_r[wr_ptr_r] <= bus.cpu_sign_mask;
        wr_ptr_r              <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Cache port sequencer: issue from idle, one-cycle request pulse, then wait out the cache stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= M_IDLE;
      op_r             <= OP_STORE;
      mem_addr_r       <= 32'h0;
      mem_write_data_r <= 32'h0;
      mem_sign_mask_r  <= 4'h0;
      mem_memwrite_r   <= 1'b0;
      mem_memread_r    <= 1'b0;
    end else begin
      mem_memwrite_r <= 1'b0;
      mem_memread_r  <= 1'b0;
      case (state_r)
        M_IDLE: begin
          if (!bus.mem_clk_stall && bus.cpu_memread && !hazard_s) begin
            mem_addr_r       <= bus.cpu_addr;
            mem_write_data_r <= bus.cpu_write_data;
            mem_sign_mask_r  <= bus.cpu_sign_mask;
            mem_memread_r    <= 1'b1;
            op_r             <= OP_LOAD;
            state_r          <= M_REQ;
          end else if (!bus.mem_clk_stall && (count_r != '0)) begin
            mem_addr_r       <= fifo_addr_r[rd_ptr_r];
            mem_write_data_r <= fifo_data_r[rd_ptr_r];
            mem_sign_mask_r  <= fifo_mask_r[rd_ptr_r];
            mem_memwrite_r   <= 1'b1;
            op_r             <= OP_STORE;
            state_r          <= M_REQ;
          end else begin
            state_r <= M_IDLE;
          end
        end
        M_REQ:   state_r <= M_WAIT;
        M_WAIT:  state_r <= bus.mem_clk_stall ? M_WAIT : M_IDLE;
        default: state_r <= M_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Scoreboard bench: stimulus pushes expected cache requests and load results, a negedge monitor pops and compares.
module tb_store_write_buffer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  store_write_buffer_if ifc ();
  store_write_buffer #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } req_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  req_t        exp_req_q[$];
  logic [31:0] exp_load_q[$];
  int          pulse_cyc_q[$];
  logic        prev_pulse = 1'b0;

  // Cache model: a request pulse makes it busy for the two following cycles.
  logic [31:0] cmem [logic [29:0]];
  int          busy_cnt = 0;
  logic [31:0] rd_data = 32'h0;
  logic        force_busy = 1'b0;
  assign ifc.mem_read_data = rd_data;
  assign ifc.mem_clk_stall = (busy_cnt != 0) || force_busy;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (ifc.mem_memwrite) begin
      cmem[ifc.mem_addr[31:2]] = ifc.mem_write_data;
      busy_cnt <= 2;
    end
    if (ifc.mem_memread) begin
      rd_data  <= cmem.exists(ifc.mem_addr[31:2]) ? cmem[ifc.mem_addr[31:2]] : 32'h0;
      busy_cnt <= 2;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic req_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m);
    req_t r;
    r.wr = wr; r.addr = a; r.data = d; r.mask = m;
    return r;
  endfunction

  // Monitor: every cache request and every released load is compared against the queues.
  always @(negedge clk) begin
    req_t e;
    if (rst_n) begin
      if (ifc.mem_memwrite || ifc.mem_memread) begin
        pulse_cyc_q.push_back(cyc);
        chk("pulse_width", {31'h0, prev_pulse}, 32'h0);
        if (exp_req_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_req: got addr %h wr %b expected none", ifc.mem_addr, ifc.mem_memwrite);
        end else begin
          e = exp_req_q.pop_front();
          chk("req_write", {31'h0, ifc.mem_memwrite}, {31'h0, e.wr});
          chk("req_read", {31'h0, ifc.mem_memread}, {31'h0, ~e.wr});
          chk("req_addr", ifc.mem_addr, e.addr);
          chk("req_mask", {28'h0, ifc.mem_sign_mask}, {28'h0, e.mask});
          if (e.wr) chk("req_data", ifc.mem_write_data, e.data);
        end
      end
      if (ifc.cpu_memread && !ifc.cpu_stall) begin
        if (exp_load_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_load: got %h expected none", ifc.cpu_read_data);
        end else begin
          chk("load_data", ifc.cpu_read_data, exp_load_q.pop_front());
        end
      end
      prev_pulse = ifc.mem_memwrite || ifc.mem_memread;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic cpu_op(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output int stalls);
    ifc.cpu_addr       = a;
    ifc.cpu_write_data = d;
    ifc.cpu_sign_mask  = m;
    ifc.cpu_memwrite   = wr;
    ifc.cpu_memread    = ~wr;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!ifc.cpu_stall) break;
      stalls++;
      if (stalls > 100) begin
        checks++; failures++;
        $display("FAIL cpu_op_timeout: got %0d stall cycles expected at most 100", stalls);
        break;
      end
    end
    @(posedge clk); #1;
    ifc.cpu_memwrite = 1'b0;
    ifc.cpu_memread  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_req_q.size() != 0 || ifc.mem_clk_stall) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_req_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int st;
    ifc.cpu_addr = 32'h0; ifc.cpu_write_data = 32'h0; ifc.cpu_sign_mask = 4'h0;
    ifc.cpu_memwrite = 1'b0; ifc.cpu_memread = 1'b0;
    cmem[30'h40] = 32'hDEADBEEF;
    cmem[30'h20] = 32'h12345678;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_memwrite", {31'h0, ifc.mem_memwrite}, 32'h0);
    chk("rst_memread", {31'h0, ifc.mem_memread}, 32'h0);
    chk("rst_addr", ifc.mem_addr, 32'h0);
    chk("rst_stall", {31'h0, ifc.cpu_stall}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single load from idle.
    pulse_cyc_q.delete();
    exp_req_q.push_back(mk(1'b0, 32'h100, 32'h0, 4'h2));
    exp_load_q.push_back(32'hDEADBEEF);
    cpu_op(1'b0, 32'h100, 32'h0, 4'h2, st);
    chk("load_stalls", st, 32'd4);
    wait_drain();
    chk("load_pulses", pulse_cyc_q.size(), 32'd1);

    // Posted stores: no stall, drained in order; one issue every 5 cycles.
    pulse_cyc_q.delete();
    for (int i = 0; i < 3; i++) exp_req_q.push_back(mk(1'b1, 32'h10 + 32'(4*i), 32'hA0 + 32'(i), 4'hF));
    for (int i = 0; i < 3; i++) begin
      cpu_op(1'b1, 32'h10 + 32'(4*i), 32'hA0 + 32'(i), 4'hF, st);
      chk("post_stall", st, 32'd0);
    end
    wait_drain();
    chk("post_pulses", pulse_cyc_q.size(), 32'd3);
    if (pulse_cyc_q.size() == 3) begin
      chk("post_gap0", pulse_cyc_q[1] - pulse_cyc_q[0], 32'd5);
      chk("post_gap1", pulse_cyc_q[2] - pulse_cyc_q[1], 32'd5);
    end

    // Full FIFO: fifth store waits exactly until the first completes.
    for (int i = 0; i < 5; i++) exp_req_q.push_back(mk(1'b1, 32'h40 + 32'(4*i), 32'hB0 + 32'(i), 4'h3));
    for (int i = 0; i < 5; i++) begin
      cpu_op(1'b1, 32'h40 + 32'(4*i), 32'hB0 + 32'(i), 4'h3, st);
      chk("full_stall", st, (i == 4) ? 32'd1 : 32'd0);
    end
    wait_drain();

    // Load hazard: load to the same word waits for the store, then reads it back.
    exp_req_q.push_back(mk(1'b1, 32'h20, 32'h55, 4'hF));
    exp_req_q.push_back(mk(1'b0, 32'h22, 32'h0, 4'h1));
    exp_load_q.push_back(32'h55);
    cpu_op(1'b1, 32'h20, 32'h55, 4'hF, st);
    cpu_op(1'b0, 32'h22, 32'h0, 4'h1, st);
    chk("hazard_stalls", st, 32'd9);
    wait_drain();

    // Load bypass: load issues between the two queued stores.
    exp_req_q.push_back(mk(1'b1, 32'h30, 32'h33, 4'hF));
    exp_req_q.push_back(mk(1'b0, 32'h80, 32'h0, 4'h2));
    exp_req_q.push_back(mk(1'b1, 32'h34, 32'h34, 4'hF));
    exp_load_q.push_back(32'h12345678);
    cpu_op(1'b1, 32'h30, 32'h33, 4'hF, st);
    cpu_op(1'b1, 32'h34, 32'h34, 4'hF, st);
    cpu_op(1'b0, 32'h80, 32'h0, 4'h2, st);
    chk("bypass_stalls", st, 32'd8);
    wait_drain();

    // Reset while the first of three stores is in M_WAIT.
    exp_req_q.push_back(mk(1'b1, 32'h60, 32'hC0, 4'hF));
    cpu_op(1'b1, 32'h60, 32'hC0, 4'hF, st);
    cpu_op(1'b1, 32'h64, 32'hC1, 4'hF, st);
    cpu_op(1'b1, 32'h68, 32'hC2, 4'hF, st);
    force_busy = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_memwrite", {31'h0, ifc.mem_memwrite}, 32'h0);
    chk("mid_rst_addr", ifc.mem_addr, 32'h0);
    chk("mid_rst_data", ifc.mem_write_data, 32'h0);
    pulse_cyc_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_issue_busy", pulse_cyc_q.size(), 32'd0);
    force_busy = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("no_stale_drain", pulse_cyc_q.size(), 32'd0);
    exp_req_q.push_back(mk(1'b1, 32'h70, 32'hD0, 4'hF));
    cpu_op(1'b1, 32'h70, 32'hD0, 4'hF, st);
    wait_drain();
    chk("post_rst_pulses", pulse_cyc_q.size(), 32'd1);
    chk("leftover_loads", exp_load_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
